// File: rtl/params_pkg.sv
// Shared parameters and types for the memory-side arbiter.
// Line width and physical address width are fixed here for the whole core.
package params_pkg;

    localparam int unsigned PADDR_WIDTH      = 32;
    localparam int unsigned CACHE_LINE_BYTES = 16;

    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HALF  = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } access_size_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } arb_owner_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between instruction and data cache requests.
// MEM_ARB_RR_EN selects round-robin; otherwise the data cache has fixed priority.
module mem_arb_pick
    import params_pkg::*;
(
    input  logic       ic_req,
    input  logic       dc_req,
    input  arb_owner_t last_owner,
    output arb_owner_t winner
);

`ifdef MEM_ARB_RR_EN
    always_comb begin
        if (ic_req && dc_req) begin
            // On contention the side that did not win last time goes first
            winner = (last_owner == OWN_IC) ? OWN_DC : OWN_IC;
        end else if (dc_req) begin
            winner = OWN_DC;
        end else begin
            winner = OWN_IC;
        end
    end
`else
    logic w_unused_inputs;
    assign w_unused_inputs = ic_req ^ last_owner;

    always_comb begin
        winner = dc_req ? OWN_DC : OWN_IC;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-client memory arbiter (I-cache / D-cache), one transaction outstanding.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is D-cache priority.
module mem_arbiter
    import params_pkg::*;
#(
    parameter int unsigned PADDR_WIDTH = params_pkg::PADDR_WIDTH,
    parameter int unsigned LINE_WIDTH  = params_pkg::CACHE_LINE_BYTES * 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   ic_req_i,
    input  logic [PADDR_WIDTH-1:0] ic_addr_i,
    output logic                   ic_gnt_o,
    output logic                   ic_rvalid_o,
    output logic [LINE_WIDTH-1:0]  ic_rdata_o,

    input  logic                   dc_req_i,
    input  logic                   dc_we_i,
    input  logic [PADDR_WIDTH-1:0] dc_addr_i,
    input  logic [LINE_WIDTH-1:0]  dc_wdata_i,
    input  access_size_t           dc_size_i,
    output logic                   dc_gnt_o,
    output logic                   dc_rvalid_o,
    output logic [LINE_WIDTH-1:0]  dc_rdata_o,

    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [PADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_WIDTH-1:0]  mem_wdata_o,
    output access_size_t           mem_size_o,
    input  logic                   mem_rvalid_i,
    input  logic [LINE_WIDTH-1:0]  mem_rdata_i
);

    arb_state_t r_state;
    arb_owner_t r_owner;
    arb_owner_t w_winner;
    arb_owner_t w_last_owner;
    logic       w_any_req;

    assign w_any_req = ic_req_i | dc_req_i;

`ifdef MEM_ARB_RR_EN
    arb_owner_t r_last_owner;
    assign w_last_owner = r_last_owner;
`else
    assign w_last_owner = OWN_IC;
`endif

    mem_arb_pick u_pick (
        .ic_req     (ic_req_i),
        .dc_req     (dc_req_i),
        .last_owner (w_last_owner),
        .winner     (w_winner)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_owner      <= OWN_IC;
`ifdef MEM_ARB_RR_EN
            r_last_owner <= OWN_IC;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state      <= BUSY;
                        r_owner      <= w_winner;
`ifdef MEM_ARB_RR_EN
                        r_last_owner <= w_winner;
`endif
                    end
                end
                BUSY: begin
                    if (mem_rvalid_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Grant and response are combinational so neither path adds a cycle
    always_comb begin
        ic_gnt_o    = 1'b0;
        dc_gnt_o    = 1'b0;
        ic_rvalid_o = 1'b0;
        dc_rvalid_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_size_o  = WORD;

        if ((r_state == IDLE) && w_any_req) begin
            mem_req_o = 1'b1;
            if (w_winner == OWN_DC) begin
                dc_gnt_o    = 1'b1;
                mem_we_o    = dc_we_i;
                mem_addr_o  = dc_addr_i;
                mem_wdata_o = dc_wdata_i;
                mem_size_o  = dc_size_i;
            end else begin
                ic_gnt_o    = 1'b1;
                mem_addr_o  = ic_addr_i;
            end
        end

        if ((r_state == BUSY) && mem_rvalid_i) begin
            ic_rvalid_o = (r_owner == OWN_IC);
            dc_rvalid_o = (r_owner == OWN_DC);
        end
    end

    assign ic_rdata_o = mem_rdata_i;
    assign dc_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed transactions push expectations,
// a negedge monitor pops and compares grants and responses.
module tb_mem_arbiter;
    import params_pkg::*;

    localparam int unsigned AW = params_pkg::PADDR_WIDTH;
    localparam int unsigned LW = params_pkg::CACHE_LINE_BYTES * 8;

    typedef struct {
        arb_owner_t   owner;
        logic         we;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        access_size_t size;
        int           gap;
    } gnt_exp_t;

    typedef struct {
        arb_owner_t    owner;
        logic [LW-1:0] data;
        int            lat;
    } rsp_exp_t;

    logic          clk;
    logic          rst_i;
    logic          ic_req_i;
    logic [AW-1:0] ic_addr_i;
    logic          ic_gnt_o, ic_rvalid_o;
    logic [LW-1:0] ic_rdata_o;
    logic          dc_req_i, dc_we_i;
    logic [AW-1:0] dc_addr_i;
    logic [LW-1:0] dc_wdata_i;
    access_size_t  dc_size_i;
    logic          dc_gnt_o, dc_rvalid_o;
    logic [LW-1:0] dc_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [LW-1:0] mem_wdata_o;
    access_size_t  mem_size_o;
    logic          mem_rvalid_i;
    logic [LW-1:0] mem_rdata_i;

    mem_arbiter #(
        .PADDR_WIDTH (AW),
        .LINE_WIDTH  (LW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ic_req_i     (ic_req_i),
        .ic_addr_i    (ic_addr_i),
        .ic_gnt_o     (ic_gnt_o),
        .ic_rvalid_o  (ic_rvalid_o),
        .ic_rdata_o   (ic_rdata_o),
        .dc_req_i     (dc_req_i),
        .dc_we_i      (dc_we_i),
        .dc_addr_i    (dc_addr_i),
        .dc_wdata_i   (dc_wdata_i),
        .dc_size_i    (dc_size_i),
        .dc_gnt_o     (dc_gnt_o),
        .dc_rvalid_o  (dc_rvalid_o),
        .dc_rdata_o   (dc_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_size_o   (mem_size_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_gnt_cyc = 0;
    int last_rsp_cyc = 0;
    int mem_lat = 1;
    bit mem_busy = 1'b0;
    bit tb_busy = 1'b0;
    gnt_exp_t gq[$];
    rsp_exp_t rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
        return {a ^ 32'hC0DE_0000, ~a, a + 32'h0000_1111, a ^ 32'hFACE_0000};
    endfunction

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory model: answers each request after mem_lat cycles
    initial begin
        logic [LW-1:0] d;
        int            lat;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(negedge clk);
            if (mem_req_o) begin
                mem_busy = 1'b1;
                lat = mem_lat;
                d   = mem_line(mem_addr_o);
                repeat (lat) @(posedge clk);
                #1;
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = d;
                @(posedge clk);
                #1;
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = {4{32'h0BAD_F00D}};
                mem_busy     = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        gnt_exp_t ge;
        rsp_exp_t re;
        if (!rst_i) begin
            chk("gnt_onehot", LW'(ic_gnt_o & dc_gnt_o), '0);
            chk("rvalid_onehot", LW'(ic_rvalid_o & dc_rvalid_o), '0);
            chk("req_only_idle", LW'(tb_busy & mem_req_o), '0);
            chk("req_eq_gnt", LW'(mem_req_o), LW'(ic_gnt_o | dc_gnt_o));
            chk("ic_rdata_pass", ic_rdata_o, mem_rdata_i);
            chk("dc_rdata_pass", dc_rdata_o, mem_rdata_i);
            if (ic_gnt_o || dc_gnt_o) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_unexpected: got ic=%0b dc=%0b expected no grant (cycle %0d)",
                             ic_gnt_o, dc_gnt_o, cyc);
                end else begin
                    ge = gq.pop_front();
                    chk("gnt_owner", LW'(dc_gnt_o), LW'(ge.owner));
                    chk("gnt_we", LW'(mem_we_o), LW'(ge.we));
                    chk("gnt_addr", LW'(mem_addr_o), LW'(ge.addr));
                    chk("gnt_wdata", mem_wdata_o, ge.wdata);
                    chk("gnt_size", LW'(mem_size_o), LW'(ge.size));
                    if (ge.gap != 0) chk("gnt_gap", LW'(cyc - last_rsp_cyc), LW'(ge.gap));
                end
                last_gnt_cyc = cyc;
            end
            if (ic_rvalid_o || dc_rvalid_o) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got ic=%0b dc=%0b expected no rvalid (cycle %0d)",
                             ic_rvalid_o, dc_rvalid_o, cyc);
                end else begin
                    re = rq.pop_front();
                    chk("rsp_owner", LW'(dc_rvalid_o), LW'(re.owner));
                    chk("rsp_ic_data", ic_rdata_o, re.data);
                    chk("rsp_dc_data", dc_rdata_o, re.data);
                    if (re.lat != 0) chk("rsp_latency", LW'(cyc - last_gnt_cyc), LW'(re.lat));
                end
                last_rsp_cyc = cyc;
            end
        end
        if (rst_i) tb_busy = 1'b0;
        else if (ic_gnt_o || dc_gnt_o) tb_busy = 1'b1;
        else if (tb_busy && mem_rvalid_i) tb_busy = 1'b0;
    end

    task automatic exp_gnt(input arb_owner_t o, input logic we, input logic [AW-1:0] a,
                           input logic [LW-1:0] wd, input access_size_t sz, input int gap);
        gnt_exp_t e;
        e.owner = o; e.we = we; e.addr = a; e.wdata = wd; e.size = sz; e.gap = gap;
        gq.push_back(e);
    endtask

    task automatic exp_rsp(input arb_owner_t o, input logic [AW-1:0] a, input int lat);
        rsp_exp_t e;
        e.owner = o; e.data = mem_line(a); e.lat = lat;
        rq.push_back(e);
    endtask

    task automatic wait_gnt(input bit dc, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = dc ? dc_gnt_o : ic_gnt_o;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: got no grant within 50 cycles, expected a grant", name);
        end
    endtask

    task automatic issue_ic(input logic [AW-1:0] a);
        ic_req_i  = 1'b1;
        ic_addr_i = a;
        wait_gnt(1'b0, "ic_gnt_timeout");
        @(posedge clk); #1;
        ic_req_i  = 1'b0;
        ic_addr_i = '0;
    endtask

    task automatic issue_dc(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] wd,
                            input access_size_t sz);
        dc_req_i   = 1'b1;
        dc_we_i    = we;
        dc_addr_i  = a;
        dc_wdata_i = wd;
        dc_size_i  = sz;
        wait_gnt(1'b1, "dc_gnt_timeout");
        @(posedge clk); #1;
        dc_req_i   = 1'b0;
        dc_we_i    = 1'b0;
        dc_addr_i  = '0;
        dc_wdata_i = '0;
        dc_size_i  = WORD;
    endtask

    task automatic wait_idle();
        bit done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            done = (gq.size() == 0) && (rq.size() == 0) && !mem_busy;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got gq=%0d rq=%0d mem_busy=%0b, expected drained",
                     gq.size(), rq.size(), mem_busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string name);
        @(negedge clk);
        chk({name, "_ctrl"}, LW'({mem_req_o, mem_we_o, ic_gnt_o, dc_gnt_o, ic_rvalid_o, dc_rvalid_o}),
            '0);
        chk({name, "_addr"}, LW'(mem_addr_o), '0);
        chk({name, "_wdata"}, mem_wdata_o, '0);
        chk({name, "_size"}, LW'(mem_size_o), LW'(WORD));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_i      = 1'b1;
        ic_req_i   = 1'b0;
        ic_addr_i  = '0;
        dc_req_i   = 1'b0;
        dc_we_i    = 1'b0;
        dc_addr_i  = '0;
        dc_wdata_i = '0;
        dc_size_i  = WORD;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        check_idle_outputs("reset");
        @(posedge clk); #1;

        // IC only, latency 3
        mem_lat = 3;
        exp_gnt(OWN_IC, 1'b0, 32'h1040, '0, WORD, 0);
        exp_rsp(OWN_IC, 32'h1040, 3);
        issue_ic(32'h1040);
        wait_idle();

        // Both requesting continuously
        mem_lat = 2;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            if (k % 2 == 0) begin
                exp_gnt(OWN_DC, 1'b0, 32'h4000, '0, HALF, (k == 0) ? 0 : 1);
                exp_rsp(OWN_DC, 32'h4000, 2);
            end else begin
                exp_gnt(OWN_IC, 1'b0, 32'h3000, '0, WORD, 1);
                exp_rsp(OWN_IC, 32'h3000, 2);
            end
`else
            exp_gnt(OWN_DC, 1'b0, 32'h4000, '0, HALF, (k == 0) ? 0 : 1);
            exp_rsp(OWN_DC, 32'h4000, 2);
`endif
        end
        ic_req_i  = 1'b1;
        ic_addr_i = 32'h3000;
        dc_req_i  = 1'b1;
        dc_we_i   = 1'b0;
        dc_addr_i = 32'h4000;
        dc_size_i = HALF;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            if (ic_gnt_o || dc_gnt_o) n++;
        end
        @(posedge clk); #1;
        ic_req_i  = 1'b0;
        ic_addr_i = '0;
        dc_req_i  = 1'b0;
        dc_addr_i = '0;
        dc_size_i = WORD;
        if (n < 4) begin
            checks++;
            errors++;
            $display("FAIL contention_grants: got %0d grants expected 4", n);
        end
        wait_idle();

        // DC write
        mem_lat = 2;
        exp_gnt(OWN_DC, 1'b1, 32'h2000, {16{8'hA5}}, WORD, 0);
        exp_rsp(OWN_DC, 32'h2000, 2);
        issue_dc(1'b1, 32'h2000, {16{8'hA5}}, WORD);
        wait_idle();

        // IC arrives while DC is outstanding: granted the cycle after the DC response
        mem_lat = 3;
        exp_gnt(OWN_DC, 1'b0, 32'h7000, '0, BYTE, 0);
        exp_gnt(OWN_IC, 1'b0, 32'h7040, '0, WORD, 1);
        exp_rsp(OWN_DC, 32'h7000, 3);
        exp_rsp(OWN_IC, 32'h7040, 3);
        issue_dc(1'b0, 32'h7000, '0, BYTE);
        issue_ic(32'h7040);
        wait_idle();

        // Reset while BUSY, then a stray response that must be ignored
        mem_lat = 4;
        exp_gnt(OWN_DC, 1'b0, 32'h5000, '0, DWORD, 0);
        issue_dc(1'b0, 32'h5000, '0, DWORD);
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        check_idle_outputs("busy_reset");
        wait_idle();
        mem_lat = 1;
        exp_gnt(OWN_IC, 1'b0, 32'h6000, '0, WORD, 0);
        exp_rsp(OWN_IC, 32'h6000, 1);
        issue_ic(32'h6000);
        wait_idle();

        chk("gnt_queue_drained", LW'(gq.size()), '0);
        chk("rsp_queue_drained", LW'(rq.size()), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
